// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the maintenance-unit arbiter.
// Holds the FSM state enum, the completed-grant saturation limit and a one-hot-to-index helper.
package arbitro_pkg;

    typedef enum logic [1:0] {
        REPOSO       = 2'b00,
        ACTIVO       = 2'b01,
        ENFRIAMIENTO = 2'b10,
        ERROR        = 2'b11
    } estado_arb_t;

    localparam logic [7:0] CONT_MAX = 8'd255;

    // Index of the set bit of a one-hot word (up to 16 requesters).
    function automatic logic [3:0] onehot_a_idx(input logic [15:0] oh);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arbitro_mantenimiento_selector_rr.sv
// selector_rr: combinational requester search.
// Ports: solicitud (requests), puntero (search start) -> idx (winner), valido (any request).
// Macro ARB_PRIORIDAD_FIJA_EN: lowest set index wins and puntero is ignored.
module selector_rr
    import arbitro_pkg::*;
#(
    parameter int N_SOLIC = 4,
    parameter int ID_W    = $clog2(N_SOLIC)
) (
    input  logic [N_SOLIC-1:0] solicitud,
    input  logic [ID_W-1:0]    puntero,
    output logic [ID_W-1:0]    idx,
    output logic               valido
);

`ifdef ARB_PRIORIDAD_FIJA_EN
    logic unused_puntero;
    assign unused_puntero = ^puntero;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        idx    = '0;
        valido = 1'b0;
        for (int i = N_SOLIC - 1; i >= 0; i--) begin
            if (solicitud[i]) begin
                idx    = ID_W'(i);
                valido = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] cand;

    // Scan offsets from farthest to nearest; the nearest set bit at or
    // after puntero (with wrap) is the last one written.
    always_comb begin
        idx    = '0;
        valido = 1'b0;
        cand   = '0;
        for (int k = N_SOLIC - 1; k >= 0; k--) begin
            cand = ID_W'((int'(puntero) + k) % N_SOLIC);
            if (solicitud[cand]) begin
                idx    = cand;
                valido = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/arbitro_mantenimiento.sv
// Round-robin arbiter with hold-time watchdog for the shared maintenance unit.
// Ports: reloj, reset (async, active low), solicitud, liberar, limpiar_error in;
// concesion (one-hot grant), estado_actual, error_flag, error_id, estado_registro out.
// Macro ARB_PRIORIDAD_FIJA_EN selects fixed lowest-index priority instead of round-robin.
module arbitro_mantenimiento
    import arbitro_pkg::*;
#(
    parameter int N_SOLIC = 4,
    parameter int TIMEOUT = 16,
    parameter int ID_W    = $clog2(N_SOLIC)
) (
    input  logic               reloj,
    input  logic               reset,
    input  logic [N_SOLIC-1:0] solicitud,
    input  logic [N_SOLIC-1:0] liberar,
    input  logic               limpiar_error,
    output logic [N_SOLIC-1:0] concesion,
    output logic [1:0]         estado_actual,
    output logic               error_flag,
    output logic [ID_W-1:0]    error_id,
    output logic [7:0]         estado_registro
);

    localparam int T_W = $clog2(TIMEOUT);

    estado_arb_t        estado, estado_sig;
    logic [N_SOLIC-1:0] conc_sig;
    logic [T_W-1:0]     timer, timer_sig;
    logic [ID_W-1:0]    puntero;
    logic [ID_W-1:0]    sel_idx, gnt_idx, err_id_sig;
    logic               sel_valido, err_sig;
    logic [7:0]         cont_sig;
    logic               lib_g, sol_g, vence;

    assign estado_actual = estado;

    selector_rr #(
        .N_SOLIC (N_SOLIC),
        .ID_W    (ID_W)
    ) u_sel (
        .solicitud (solicitud),
        .puntero   (puntero),
        .idx       (sel_idx),
        .valido    (sel_valido)
    );

    assign gnt_idx = ID_W'(onehot_a_idx(16'(concesion)));
    assign lib_g   = liberar[gnt_idx];
    assign sol_g   = solicitud[gnt_idx];
    assign vence   = (timer == T_W'(TIMEOUT - 1));

`ifdef ARB_PRIORIDAD_FIJA_EN
    assign puntero = '0;
`else
    logic [ID_W-1:0] puntero_sig;

    assign puntero_sig = (sel_idx == ID_W'(N_SOLIC - 1)) ?
                         '0 : sel_idx + 1'b1;

    // Advance only when a grant is issued from REPOSO.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            puntero <= '0;
        end else if (estado == REPOSO && sel_valido) begin
            puntero <= puntero_sig;
        end
    end
`endif

    always_comb begin
        estado_sig = estado;
        conc_sig   = concesion;
        timer_sig  = timer;
        err_sig    = error_flag;
        err_id_sig = error_id;
        cont_sig   = estado_registro;
        unique case (estado)
            REPOSO: begin
                if (sel_valido) begin
                    conc_sig   = {{(N_SOLIC-1){1'b0}}, 1'b1} << sel_idx;
                    timer_sig  = '0;
                    estado_sig = ACTIVO;
                end
            end
            ACTIVO: begin
                timer_sig = timer + 1'b1;
                // Release has priority over both abandonment and timeout.
                if (lib_g) begin
                    conc_sig   = '0;
                    estado_sig = ENFRIAMIENTO;
                    if (estado_registro != CONT_MAX) begin
                        cont_sig = estado_registro + 8'd1;
                    end
                end else if (!sol_g) begin
                    conc_sig   = '0;
                    estado_sig = ENFRIAMIENTO;
                end else if (vence) begin
                    conc_sig   = '0;
                    err_sig    = 1'b1;
                    err_id_sig = gnt_idx;
                    estado_sig = ERROR;
                end
            end
            ENFRIAMIENTO: begin
                estado_sig = REPOSO;
            end
            ERROR: begin
                if (limpiar_error) begin
                    err_sig    = 1'b0;
                    estado_sig = REPOSO;
                end
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            concesion       <= '0;
            timer           <= '0;
            error_flag      <= 1'b0;
            error_id        <= '0;
            estado_registro <= '0;
        end else begin
            concesion       <= conc_sig;
            timer           <= timer_sig;
            error_flag      <= err_sig;
            error_id        <= err_id_sig;
            estado_registro <= cont_sig;
        end
    end

endmodule

// File: tb/tb_arbitro_mantenimiento.sv
// Self-checking bench for arbitro_mantenimiento (N_SOLIC=4, TIMEOUT=16).
// Directed stimulus, behavioural reference model and literal pins.
module tb_arbitro_mantenimiento;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         reloj = 1'b0;
    logic         reset;
    logic [N-1:0] solicitud;
    logic [N-1:0] liberar;
    logic         limpiar_error;
    logic [N-1:0] concesion;
    logic [1:0]   estado_actual;
    logic         error_flag;
    logic [1:0]   error_id;
    logic [7:0]   estado_registro;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 reloj = ~reloj;

    arbitro_mantenimiento #(
        .N_SOLIC (N),
        .TIMEOUT (TO)
    ) dut (
        .reloj           (reloj),
        .reset           (reset),
        .solicitud       (solicitud),
        .liberar         (liberar),
        .limpiar_error   (limpiar_error),
        .concesion       (concesion),
        .estado_actual   (estado_actual),
        .error_flag      (error_flag),
        .error_id        (error_id),
        .estado_registro (estado_registro)
    );

    // Reference model: who holds the grant, for how long, cooldown,
    // error latch, completed count and next search start.
    int m_grant, m_hold, m_next, m_count, m_err_id;
    bit m_cool, m_err;

    always @(posedge reloj or negedge reset) begin : model
        int g, h, nx, c, e, j;
        bit cl, er;
        if (!reset) begin
            m_grant  <= -1;
            m_hold   <= 0;
            m_next   <= 0;
            m_count  <= 0;
            m_err_id <= 0;
            m_cool   <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            g = m_grant; h = m_hold; nx = m_next;
            c = m_count; e = m_err_id; cl = m_cool; er = m_err;
            if (er) begin
                if (limpiar_error) er = 1'b0;
            end else if (g >= 0) begin
                if (liberar[g]) begin
                    if (c < 255) c = c + 1;
                    g = -1; cl = 1'b1;
                end else if (!solicitud[g]) begin
                    g = -1; cl = 1'b1;
                end else begin
                    h = h + 1;
                    if (h == TO) begin
                        er = 1'b1; e = g; g = -1;
                    end
                end
            end else if (cl) begin
                cl = 1'b0;
            end else if (solicitud != 0) begin
                for (int k = 0; k < N; k++) begin
                    j = (nx + k) % N;
                    if (g < 0 && solicitud[j]) g = j;
                end
                h = 0;
`ifndef ARB_PRIORIDAD_FIJA_EN
                nx = (g + 1) % N;
`endif
            end
            m_grant <= g; m_hold <= h; m_next <= nx;
            m_count <= c; m_err_id <= e; m_cool <= cl; m_err <= er;
        end
    end

    function automatic logic [N-1:0] oh(input int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] m_estado();
        if (m_err) return 2'b11;
        if (m_grant >= 0) return 2'b01;
        if (m_cool) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge reloj) begin
        if (chk_en && reset) begin
            chk("m.concesion", 32'(concesion), 32'(oh(m_grant)));
            chk("m.estado", 32'(estado_actual), 32'(m_estado()));
            chk("m.error_flag", 32'(error_flag), 32'(m_err));
            chk("m.error_id", 32'(error_id), 32'(m_err_id[1:0]));
            chk("m.registro", 32'(estado_registro), 32'(m_count));
        end
    end

    task automatic step();
        @(posedge reloj);
        #2;
    endtask

    logic [N-1:0] exp2;
    logic [N-1:0] expf [3];

    initial begin
`ifdef ARB_PRIORIDAD_FIJA_EN
        exp2 = 4'b0010;
        expf = '{4'b0010, 4'b0010, 4'b0010};
`else
        exp2 = 4'b1000;
        expf = '{4'b0010, 4'b1000, 4'b0010};
`endif
        reset = 1'b0;
        solicitud = '0;
        liberar = '0;
        limpiar_error = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        chk("rst.concesion", 32'(concesion), 0);
        chk("rst.estado", 32'(estado_actual), 0);
        chk("rst.flag", 32'(error_flag), 0);
        chk("rst.id", 32'(error_id), 0);
        chk("rst.registro", 32'(estado_registro), 0);
        chk_en = 1'b1;

        // Basic grant / release
        solicitud = 4'b1010;
        step();
        chk("rr.g1", 32'(concesion), 32'h2);
        chk("rr.g1.est", 32'(estado_actual), 1);
        liberar = oh(m_grant);
        step();
        liberar = '0;
        chk("rr.rel.est", 32'(estado_actual), 2);
        chk("rr.rel.cnt", 32'(estado_registro), 1);
        step();
        chk("rr.idle.est", 32'(estado_actual), 0);
        step();
        chk("rr.g2", 32'(concesion), 32'(exp2));
        liberar = oh(m_grant);
        step();
        liberar = '0;
        solicitud = '0;
        chk("rr.cnt2", 32'(estado_registro), 2);
        step();

        // Watchdog timeout
        solicitud = 4'b0001;
        step();
        chk("to.g", 32'(concesion), 32'h1);
        repeat (TO - 1) step();
        chk("to.held", 32'(estado_actual), 1);
        step();
        chk("to.est", 32'(estado_actual), 3);
        chk("to.flag", 32'(error_flag), 1);
        chk("to.id", 32'(error_id), 0);
        chk("to.conc", 32'(concesion), 0);
        solicitud = 4'b1111;
        repeat (3) step();
        chk("err.nogrant", 32'(concesion), 0);
        chk("err.est", 32'(estado_actual), 3);
        limpiar_error = 1'b1;
        solicitud = '0;
        step();
        limpiar_error = 1'b0;
        chk("clr.est", 32'(estado_actual), 0);
        chk("clr.flag", 32'(error_flag), 0);

        // Release on the same edge as the timeout
        solicitud = 4'b0100;
        step();
        chk("tie.g", 32'(concesion), 32'h4);
        repeat (TO - 1) step();
        liberar = 4'b0100;
        step();
        liberar = '0;
        solicitud = '0;
        chk("tie.est", 32'(estado_actual), 2);
        chk("tie.flag", 32'(error_flag), 0);
        chk("tie.cnt", 32'(estado_registro), 3);
        step();

        // Abandonment
        solicitud = 4'b0001;
        step();
        repeat (3) step();
        solicitud = '0;
        step();
        chk("ab.est", 32'(estado_actual), 2);
        chk("ab.cnt", 32'(estado_registro), 3);
        step();

        // Saturation
        solicitud = 4'b1111;
        repeat (260) begin
            step();
            liberar = oh(m_grant);
            step();
            liberar = '0;
            step();
        end
        chk("sat.cnt", 32'(estado_registro), 255);
        solicitud = '0;
        step();

        // Asynchronous reset mid-grant
        solicitud = 4'b0010;
        step();
        chk("ar.g", 32'(concesion), 32'h2);
        #1 reset = 1'b0;
        #1;
        chk("ar.conc", 32'(concesion), 0);
        chk("ar.est", 32'(estado_actual), 0);
        chk("ar.cnt", 32'(estado_registro), 0);
        chk("ar.flag", 32'(error_flag), 0);
        solicitud = '0;
        reset = 1'b1;
        step();

        // Repeated requests on 1010
        solicitud = 4'b1010;
        for (int g = 0; g < 3; g++) begin
            step();
            chk($sformatf("seq.g%0d", g), 32'(concesion), 32'(expf[g]));
            liberar = oh(m_grant);
            step();
            liberar = '0;
            step();
        end
        solicitud = '0;
        step();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arbitro_mantenimiento.md
Name: arbitro_mantenimiento

Overview:
- Round-robin arbiter and watchdog for the shared maintenance unit that SistemaControl drives.
- Up to N_SOLIC requesters each raise `solicitud`. The arbiter grants exactly one of them with a one-hot `concesion`, then waits for that requester to assert `liberar`.
- A hold-time watchdog raises a sticky `error_flag` if the grant is held too long.
- Status outputs (`estado_actual`, `error_flag`, `estado_registro`) match the SistemaControl status conventions.

Parameters:
- N_SOLIC, 4: number of requesters; legal range 2..16.
- TIMEOUT, 16: maximum cycles one grant may be held; minimum 2.
- ID_W, $clog2(N_SOLIC): requester index width (derived; do not override).

Ports:
- reloj  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- solicitud  in  N_SOLIC  level request per requester.
- liberar  in  N_SOLIC  single-cycle done pulse per requester.
- limpiar_error  in  1  pulse that clears the ERROR state.
- concesion  out  N_SOLIC  one-hot grant, registered.
- estado_actual  out  2  FSM state code.
- error_flag  out  1  sticky watchdog error.
- error_id  out  ID_W  index of the requester that timed out.
- estado_registro  out  8  count of completed grants, saturating.

Behaviour:
- Reset (reset=0, asynchronous): state goes to REPOSO; `concesion`, `error_flag`, `error_id`, `estado_registro`, hold timer and round-robin pointer all go to 0. A reset asserted mid-grant drops `concesion` immediately, with no clock edge needed.
- State encoding: REPOSO=00, ACTIVO=01, ENFRIAMIENTO=10, ERROR=11. `estado_actual` is the state register itself.
- REPOSO:
  - On an edge with `solicitud`≠0, select the first set bit at or after the pointer, searching upward with wrap-around.
  - Load `concesion` with that one-hot value; set pointer = selected index+1 mod N_SOLIC; clear the timer; go to ACTIVO.
  - Latency: a request sampled at edge k produces `concesion` valid after edge k.
- ACTIVO:
  - Timer increments by 1 each cycle.
  - `liberar` bit of the granted index = 1 → `concesion`=0, `estado_registro`+=1 (saturating at 255), go to ENFRIAMIENTO.
  - `solicitud` bit of the granted index drops without `liberar` → abandonment: `concesion`=0, no count increment, go to ENFRIAMIENTO.
  - Timer == TIMEOUT-1 with neither of the above → `concesion`=0, `error_flag`=1, `error_id`=granted index, go to ERROR. A grant is therefore held at most TIMEOUT cycles.
  - `liberar` and timeout on the same edge: `liberar` wins; no error.
  - `liberar` bits of non-granted requesters are ignored.
  - Requests from other requesters are not preempted.
- ENFRIAMIENTO: exactly one cycle with `concesion`=0, then REPOSO. This guarantees at least one idle cycle between grants.
- ERROR:
  - All requests are ignored.
  - `error_flag` and `error_id` hold.
  - `limpiar_error`=1 → `error_flag`=0, go to REPOSO. The pointer and `estado_registro` are retained.
  - `limpiar_error` is ignored in every other state.
- `concesion` is never multi-hot and is 0 outside ACTIVO.

Optional Feature:
- Macro: ARB_PRIORIDAD_FIJA_EN.
- Defined: fixed priority. The lowest set index in `solicitud` always wins; the pointer is not implemented.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Package `arbitro_pkg`:
  - `estado_arb_t` enum: REPOSO, ACTIVO, ENFRIAMIENTO, ERROR, with the 2-bit codes above.
  - Constant CONT_MAX=8'd255.
  - Function `onehot_a_idx`.
- Sub-module `selector_rr`:
  - Purely combinational.
  - Inputs: `solicitud`, `puntero`. Outputs: `idx`, `valido`.
  - Implements both the round-robin and the fixed-priority search.

Test Plan (N_SOLIC=4, TIMEOUT=16):
- Reset: with concesion=0010 in ACTIVO, pulse reset=0 between edges → `concesion`=0000 and `estado_actual`=00 immediately; all outputs 0.
- Round-robin: after reset, solicitud=1010 → concesion=0010 one edge later, estado=01. liberar=0010 → estado=10, then 00. Next grant is concesion=1000. `estado_registro` reads 1, then 2 after that grant is released.
- Timeout: solicitud=0001 with no liberar → after 16 ACTIVO cycles: `error_flag`=1, `error_id`=0, estado=11, concesion=0000. solicitud=1111 while in ERROR → no grant. limpiar_error pulse → estado=00, `error_flag`=0.
- Tie: liberar of the granted index on the edge where timer=15 → no error, `estado_registro` increments, estado=10.
- Saturation and abandonment: 260 completed grants → `estado_registro`=255. Drop `solicitud` mid-grant → estado=10, count unchanged.
- With ARB_PRIORIDAD_FIJA_EN defined: solicitud held at 1010 across 3 grants → concesion=0010 every time.
